pupil_centroid: RTL

PUPIL_CENTROID -- requirements
Module: pupil_centroid

---
 rtl/pupil_centroid.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pupil_centroid.sv
// Pupil centroid and bounding-box extractor for a raster-ordered binary mask.
// Accumulates coordinate sums per frame, then divides them with one shared
// restoring divider (x first, then y) and publishes the result for one cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_ACCUM | accepting pixels, updating sums, count and bounding box
//   S_DIV_X | 28 restoring-division steps: sum_x / count
//   S_DIV_Y | 28 restoring-division steps: sum_y / count
//   S_DONE  | result_valid pulse, then accumulators cleared
module pupil_centroid #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int FG_THRESH  = 0
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    output logic [8:0]  centroid_x,
    output logic [8:0]  centroid_y,
    output logic [18:0] pixel_count,
    output logic [8:0]  bbox_x_min,
    output logic [8:0]  bbox_x_max,
    output logic [8:0]  bbox_y_min,
    output logic [8:0]  bbox_y_max,
    output logic        found,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [8:0] LAST_COL = 9'(IMG_WIDTH - 1);
    localparam logic [8:0] LAST_ROW = 9'(IMG_HEIGHT - 1);
    localparam logic [7:0] FG_LEVEL = 8'(FG_THRESH);
    localparam logic [4:0] DIV_STEPS_M1 = 5'd27;

    typedef enum logic [1:0] {S_ACCUM, S_DIV_X, S_DIV_Y, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_col;
    logic [8:0]  r_row;
    logic [27:0] r_sum_x;
    logic [27:0] r_sum_y;
    logic [18:0] r_count;
    logic [8:0]  r_x_min, r_x_max, r_y_min, r_y_max;
    logic [19:0] r_rem;
    logic [4:0]  r_div_cnt;

    logic        w_fg;
    logic        w_accept;
    logic        w_last;
    logic        w_any;
    logic [27:0] w_dividend;
    logic [20:0] w_rem_sh;
    logic [20:0] w_sub;
    logic        w_qbit;
    logic [19:0] w_rem_next;
    logic [27:0] w_quot;

    assign w_fg     = data_in > FG_LEVEL;
    assign w_accept = data_valid && (r_state == S_ACCUM);
    assign w_last   = (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign w_any    = (r_count != 19'd0) || w_fg;

    // The sum registers double as the divider's dividend/quotient shift register.
    assign w_dividend = (r_state == S_DIV_Y) ? r_sum_y : r_sum_x;
    assign w_rem_sh   = {r_rem, w_dividend[27]};
    assign w_sub      = w_rem_sh - {2'b00, r_count};
    assign w_qbit     = ~w_sub[20];
    assign w_rem_next = w_qbit ? w_sub[19:0] : w_rem_sh[19:0];
    assign w_quot     = {w_dividend[26:0], w_qbit};

    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state != S_ACCUM);

    // State register.
    always_ff @(posedge clock) begin
        if (!rst_n) r_state <= S_ACCUM;
        else        r_state <= w_next;
    end

    // Next-state decode; a frame without foreground skips the divider.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ACCUM: if (w_accept && w_last) w_next = w_any ? S_DIV_X : S_DONE;
            S_DIV_X: if (r_div_cnt == 5'd0) w_next = S_DIV_Y;
            S_DIV_Y: if (r_div_cnt == 5'd0) w_next = S_DONE;
            S_DONE:  w_next = S_ACCUM;
            default: w_next = S_ACCUM;
        endcase
    end

    // Accumulation, division steps and result capture.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_sum_x     <= '0;
            r_sum_y     <= '0;
            r_count     <= '0;
            r_x_min     <= 9'd511;
            r_y_min     <= 9'd511;
            r_x_max     <= '0;
            r_y_max     <= '0;
            r_rem       <= '0;
            r_div_cnt   <= '0;
            centroid_x  <= '0;
            centroid_y  <= '0;
            pixel_count <= '0;
            bbox_x_min  <= '0;
            bbox_x_max  <= '0;
            bbox_y_min  <= '0;
            bbox_y_max  <= '0;
            found       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (data_valid && (r_state != S_ACCUM)) overrun <= 1'b1;
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        if (w_fg) begin
                            r_sum_x <= r_sum_x + 28'(r_col);
                            r_sum_y <= r_sum_y + 28'(r_row);
                            r_count <= r_count + 19'd1;
                            if (r_col < r_x_min) r_x_min <= r_col;
                            if (r_col > r_x_max) r_x_max <= r_col;
                            if (r_row < r_y_min) r_y_min <= r_row;
                            if (r_row > r_y_max) r_y_max <= r_row;
                        end
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= w_last ? 9'd0 : r_row + 9'd1;
                        end else begin
                            r_col <= r_col + 9'd1;
                        end
                        if (w_last) begin
                            r_div_cnt <= DIV_STEPS_M1;
                            r_rem     <= '0;
                            if (!w_any) begin
                                centroid_x  <= '0;
                                centroid_y  <= '0;
                                pixel_count <= '0;
                                bbox_x_min  <= '0;
                                bbox_x_max  <= '0;
                                bbox_y_min  <= '0;
                                bbox_y_max  <= '0;
                                found       <= 1'b0;
                            end
                        end
                    end
                end
                S_DIV_X: begin
                    r_sum_x   <= w_quot;
                    r_rem     <= w_rem_next;
                    r_div_cnt <= r_div_cnt - 5'd1;
                    if (r_div_cnt == 5'd0) begin
                        r_div_cnt <= DIV_STEPS_M1;
                        r_rem     <= '0;
                    end
                end
                S_DIV_Y: begin
                    r_sum_y   <= w_quot;
                    r_rem     <= w_rem_next;
                    r_div_cnt <= r_div_cnt - 5'd1;
                    if (r_div_cnt == 5'd0) begin
                        centroid_x  <= r_sum_x[8:0];
                        centroid_y  <= w_quot[8:0];
                        pixel_count <= r_count;
                        bbox_x_min  <= r_x_min;
                        bbox_x_max  <= r_x_max;
                        bbox_y_min  <= r_y_min;
                        bbox_y_max  <= r_y_max;
                        found       <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_col   <= '0;
                    r_row   <= '0;
                    r_sum_x <= '0;
                    r_sum_y <= '0;
                    r_count <= '0;
                    r_x_min <= 9'd511;
                    r_y_min <= 9'd511;
                    r_x_max <= '0;
                    r_y_max <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
